// File: rtl/monopix2_ro_pkg.sv
// Shared word layout, FSM state type and LE/TE Gray helper for the Monopix2 readout emulator.
// Word layout {COL, ROW, LE, TE} is fixed at 27 bits.
package monopix2_ro_pkg;

  localparam int WORD_BITS = 27;
  localparam int COL_LSB   = 21;
  localparam int COL_W     = 6;
  localparam int ROW_LSB   = 12;
  localparam int ROW_W     = 9;
  localparam int LE_LSB    = 6;
  localparam int LE_W      = 6;
  localparam int TE_LSB    = 0;
  localparam int TE_W      = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ro_state_e;

  function automatic logic [5:0] gray6(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/monopix2_ro_emu_fifo.sv
// Show-ahead synchronous hit FIFO; a write lands in 1 cycle and the head word is always on rd_dat_o.
// Backpressure: writes while full are discarded here and flagged to the caller via full_o.
module monopix2_ro_emu_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 27
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_vld_i,
  input  logic [W-1:0]               wr_dat_i,
  input  logic                       rd_rdy_i,
  output logic [W-1:0]               rd_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     occ_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_wr;
  logic         do_rd;

  assign occ_o    = wr_ptr_q - rd_ptr_q;
  assign full_o   = (occ_o == (AW+1)'(DEPTH));
  assign empty_o  = (occ_o == '0);
  assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign do_wr    = wr_vld_i & ~full_o;
  assign do_rd    = rd_rdy_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/monopix2_ro_emu.sv
// Monopix2 Freeze/Read/Token serial readout emulator; TOKEN 1 cycle, DATA bit 26 the cycle after READ edge.
// Full buffer drops hits into a saturating LOST_CNT; MONOPIX2_RO_EMU_GRAY_EN Gray-codes LE/TE on load.
module monopix2_ro_emu #(
  parameter int DEPTH     = 16,
  parameter int WORD_BITS = 27
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 hit_write_i,
  input  logic [WORD_BITS-1:0] hit_data_i,
  output logic                 hit_full_o,
  input  logic                 freeze_i,
  input  logic                 read_i,
  output logic                 token_o,
  output logic                 data_o,
  output logic [7:0]           lost_cnt_o
);

  import monopix2_ro_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_occ;
  logic [WORD_BITS-1:0] fifo_rd_dat;

  ro_state_e            state_q;
  logic [4:0]           bit_cnt_q;
  logic [WORD_BITS-1:0] sh_q;
  logic                 data_q;
  logic                 token_q;
  logic [CW-1:0]        frozen_cnt_q;
  logic [CW-1:0]        frozen_cnt_d;
  logic [7:0]           lost_cnt_q;
  logic                 freeze_q;
  logic                 read_q;

  logic                 freeze_rise;
  logic                 read_rise;
  logic                 push;
  logic                 pop;
  logic                 shift_nxt;
  logic [CW-1:0]        occ_d;
  logic                 token_d;
  logic [WORD_BITS-1:0] load_word;

  monopix2_ro_emu_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_BITS)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_vld_i (hit_write_i),
    .wr_dat_i (hit_data_i),
    .rd_rdy_i (pop),
    .rd_dat_o (fifo_rd_dat),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .occ_o    (fifo_occ)
  );

  assign freeze_rise = freeze_i & ~freeze_q;
  assign read_rise   = read_i & ~read_q;
  assign push        = hit_write_i & ~fifo_full;
  assign pop         = read_rise & freeze_i & (frozen_cnt_q != '0) &
                       (state_q == ST_IDLE) & ~fifo_empty;
  assign shift_nxt   = pop | ((state_q == ST_SHIFT) && (bit_cnt_q != 5'd0));
  assign occ_d       = fifo_occ + CW'(push) - CW'(pop);

  always_comb begin
    load_word = fifo_rd_dat;
`ifdef MONOPIX2_RO_EMU_GRAY_EN
    load_word[LE_LSB +: LE_W] = gray6(fifo_rd_dat[LE_LSB +: LE_W]);
    load_word[TE_LSB +: TE_W] = gray6(fifo_rd_dat[TE_LSB +: TE_W]);
`endif
  end

  // The frozen snapshot excludes the write landing in the same cycle as the Freeze edge.
  always_comb begin
    frozen_cnt_d = frozen_cnt_q;
    if (freeze_rise)    frozen_cnt_d = fifo_occ;
    else if (!freeze_i) frozen_cnt_d = '0;
    else if (pop)       frozen_cnt_d = frozen_cnt_q - CW'(1);
  end

  assign token_d = freeze_i ? ((frozen_cnt_d != '0) || shift_nxt) : (occ_d != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 5'd0;
      sh_q         <= '0;
      data_q       <= 1'b0;
      token_q      <= 1'b0;
      frozen_cnt_q <= '0;
      lost_cnt_q   <= 8'd0;
      freeze_q     <= 1'b0;
      read_q       <= 1'b0;
    end else begin
      freeze_q     <= freeze_i;
      read_q       <= read_i;
      frozen_cnt_q <= frozen_cnt_d;
      token_q      <= token_d;
      if (hit_write_i && fifo_full && (lost_cnt_q != 8'hFF)) begin
        lost_cnt_q <= lost_cnt_q + 8'd1;
      end
      if (state_q == ST_IDLE) begin
        data_q <= 1'b0;
        if (pop) begin
          sh_q      <= load_word;
          data_q    <= load_word[WORD_BITS-1];
          bit_cnt_q <= 5'(WORD_BITS - 1);
          state_q   <= ST_SHIFT;
        end
      end else begin
        if (bit_cnt_q == 5'd0) begin
          data_q  <= 1'b0;
          state_q <= ST_IDLE;
        end else begin
          data_q    <= sh_q[WORD_BITS-2];
          sh_q      <= sh_q << 1;
          bit_cnt_q <= bit_cnt_q - 5'd1;
        end
      end
    end
  end

  assign hit_full_o = fifo_full;
  assign token_o    = token_q;
  assign data_o     = data_q;
  assign lost_cnt_o = lost_cnt_q;

endmodule

// File: tb/tb_monopix2_ro_emu.sv
// Directed-random bench for monopix2_ro_emu against a queue-based model of the readout protocol.
module tb_monopix2_ro_emu;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hit_write = 1'b0;
  logic [26:0] hit_data = '0;
  logic        hit_full;
  logic        freeze = 1'b0;
  logic        read = 1'b0;
  logic        token;
  logic        data;
  logic [7:0]  lost_cnt;

  int checks = 0;
  int errors = 0;

  logic [26:0] mq[$];
  int          mfrozen = 0;
  int          mlost = 0;

  always #5 clk = ~clk;

  monopix2_ro_emu #(.DEPTH(DEPTH), .WORD_BITS(27)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .hit_write_i (hit_write),
    .hit_data_i  (hit_data),
    .hit_full_o  (hit_full),
    .freeze_i    (freeze),
    .read_i      (read),
    .token_o     (token),
    .data_o      (data),
    .lost_cnt_o  (lost_cnt)
  );

  initial begin
    #400000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] ser_of(input logic [26:0] w);
    logic [26:0] s;
    s = w;
`ifdef MONOPIX2_RO_EMU_GRAY_EN
    s[11:6] = w[11:6] ^ (w[11:6] >> 1);
    s[5:0]  = w[5:0] ^ (w[5:0] >> 1);
`endif
    return s;
  endfunction

  function automatic logic exp_tok();
    return freeze ? (mfrozen != 0) : (mq.size() != 0);
  endfunction

  function automatic void model_write(input logic [26:0] w, input bit was_full);
    if (was_full) begin
      if (mlost < 255) mlost++;
    end else begin
      mq.push_back(w);
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mq.delete();
    mfrozen = 0;
    mlost = 0;
  endtask

  task automatic write_hit(input logic [26:0] w);
    bit was_full;
    was_full  = (mq.size() == DEPTH);
    hit_write = 1'b1;
    hit_data  = w;
    tick();
    hit_write = 1'b0;
    model_write(w, was_full);
  endtask

  task automatic freeze_set(input logic v);
    freeze = v;
    tick();
    mfrozen = v ? mq.size() : 0;
  endtask

  // One READ pulse that must start a word; optionally a same-cycle write and a READ edge mid-word.
  task automatic read_word(input bit wr_same, input bit poke, output logic [26:0] got);
    logic [26:0] exp;
    logic [26:0] wnew;
    bit          was_full;
    wnew     = 27'($urandom);
    was_full = (mq.size() == DEPTH);
    exp      = ser_of(mq.pop_front());
    mfrozen--;
    if (wr_same) begin
      hit_write = 1'b1;
      hit_data  = wnew;
      model_write(wnew, was_full);
    end
    read = 1'b1;
    tick();
    read      = 1'b0;
    hit_write = 1'b0;
    got = '0;
    for (int k = 0; k < 27; k++) begin
      got[26-k] = data;
      if (k == 26) chk("tok_shift", token, 1'b1);
      if (poke && k == 9)  read = 1'b1;
      if (poke && k == 10) read = 1'b0;
      if (k < 26) tick();
    end
    chk("word", got, exp);
    tick();
    chk("data_idle", data, 1'b0);
    chk("tok_after", token, exp_tok());
  endtask

  task automatic ignored_read(input string tag);
    logic acc;
    acc  = 1'b0;
    read = 1'b1;
    tick();
    read = 1'b0;
    for (int k = 0; k < 28; k++) begin
      acc = acc | data;
      tick();
    end
    chk(tag, acc, 1'b0);
    chk({tag, "_tok"}, token, exp_tok());
  endtask

  initial begin
    logic [26:0] got;

    // Reset state
    do_reset();
    chk("rst_token", token, 1'b0);
    chk("rst_data", data, 1'b0);
    chk("rst_full", hit_full, 1'b0);
    chk("rst_lost", lost_cnt, 8'd0);

    // Single word, known pattern
    write_hit(27'h5A5A5A5);
    chk("tok_unfrozen", token, 1'b1);
    freeze_set(1'b1);
    chk("tok_frozen", token, 1'b1);
    read_word(1'b0, 1'b0, got);
    freeze_set(1'b0);

    // Three random words in order, READ edge mid-word ignored, fourth READ ignored
    for (int i = 0; i < 3; i++) write_hit(27'($urandom));
    freeze_set(1'b1);
    for (int i = 0; i < 3; i++) begin
      read_word(1'b0, (i == 1), got);
      tick();
      tick();
    end
    ignored_read("read_empty_frozen");
    freeze_set(1'b0);
    chk("tok_drained", token, 1'b0);

    // Words written while frozen are not counted; same-cycle write and pop
    for (int i = 0; i < 2; i++) write_hit(27'($urandom));
    freeze_set(1'b1);
    write_hit(27'($urandom));
    chk("tok_frozen2", token, 1'b1);
    read_word(1'b1, 1'b0, got);
    read_word(1'b0, 1'b0, got);
    ignored_read("read_cnt_zero");
    freeze_set(1'b0);
    chk("tok_unfreeze", token, 1'b1);
    ignored_read("read_unfrozen");
    freeze_set(1'b1);
    read_word(1'b0, 1'b0, got);
    read_word(1'b0, 1'b0, got);
    freeze_set(1'b0);
    chk("tok_empty", token, 1'b0);

    // Overflow, drop on full even with pop, saturation
    for (int i = 0; i < 18; i++) write_hit(27'($urandom));
    chk("full_18", hit_full, 1'b1);
    chk("lost_18", lost_cnt, 8'(mlost));
    chk("lost_is_2", 32'(mlost), 32'd2);
    freeze_set(1'b1);
    read_word(1'b1, 1'b0, got);
    chk("lost_pop_full", lost_cnt, 8'(mlost));
    chk("not_full", hit_full, 1'b0);
    freeze_set(1'b0);
    for (int i = 0; i < 300; i++) write_hit(27'($urandom));
    chk("full_sat", hit_full, 1'b1);
    chk("lost_sat", lost_cnt, 8'd255);

    // Reset in the middle of a word
    do_reset();
    write_hit(27'($urandom));
    freeze_set(1'b1);
    read = 1'b1;
    tick();
    read = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_data", data, 1'b0);
    chk("rst_mid_token", token, 1'b0);
    chk("rst_mid_full", hit_full, 1'b0);
    chk("rst_mid_lost", lost_cnt, 8'd0);
    freeze = 1'b0;
    tick();
    rst = 1'b0;
    mq.delete();
    mfrozen = 0;
    mlost = 0;
    tick();
    chk("post_rst_token", token, 1'b0);
    freeze_set(1'b1);
    ignored_read("post_rst_read");
    freeze_set(1'b0);

    // LE/TE field encoding on the serial line
    write_hit({6'd3, 9'd100, 6'd5, 6'd12});
    freeze_set(1'b1);
    read_word(1'b0, 1'b0, got);
`ifdef MONOPIX2_RO_EMU_GRAY_EN
    chk("le_field", got[11:6], 6'b000111);
    chk("te_field", got[5:0], 6'b001010);
`else
    chk("le_field", got[11:6], 6'd5);
    chk("te_field", got[5:0], 6'd12);
`endif
    chk("col_row", got[26:12], {6'd3, 9'd100});
    freeze_set(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
